// File: rtl/video_src_select_ctrl.sv
// Frame-synchronous select controller for the 4:1 pixel source mux, with manual request and auto-cycle modes.
// Latency: an accepted request reaches s1/s0 one cycle after the next frame_start; auto switches land one cycle after the dwell-ending frame_start.
// Backpressure: req_ready is high only in STEADY, so requests stall while a switch is pending or blanking is active.
module video_src_select_ctrl #(
    parameter int BLANK_FRAMES = 1,
    parameter int DWELL_FRAMES = 60,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_start,
    input  logic       req_valid,
    input  logic [1:0] req_sel,
    output logic       req_ready,
    input  logic       auto_en,
    output logic       s1,
    output logic       s0,
    output logic       blank,
    output logic       busy
);

    typedef enum logic [1:0] {STEADY, PENDING, BLANK} state_t;

    localparam bit               HAS_BLANK  = (BLANK_FRAMES > 0);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_FRAMES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_FRAMES > 0) ? BLANK_FRAMES - 1 : 0);

    state_t           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       pend_q, pend_d;
    logic [CNT_W-1:0] dwell_q, dwell_d;
    logic [CNT_W-1:0] blank_cnt_q, blank_cnt_d;
    logic             blank_q, blank_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= STEADY;
            sel_q       <= 2'd0;
            pend_q      <= 2'd0;
            dwell_q     <= '0;
            blank_cnt_q <= '0;
            blank_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            pend_q      <= pend_d;
            dwell_q     <= dwell_d;
            blank_cnt_q <= blank_cnt_d;
            blank_q     <= blank_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        pend_d      = pend_q;
        dwell_d     = dwell_q;
        blank_cnt_d = blank_cnt_q;
        blank_d     = blank_q;
        case (state_q)
            STEADY: begin
                // A handshake shadows both auto counting and any coincident frame_start.
                if (req_valid) begin
                    if (req_sel != sel_q) begin
                        pend_d  = req_sel;
                        dwell_d = '0;
                        state_d = PENDING;
                    end
                end else if (!auto_en) begin
                    dwell_d = '0;
                end else if (frame_start) begin
                    if (dwell_q == DWELL_LAST) begin
                        sel_d   = sel_q + 2'd1;
                        dwell_d = '0;
                        if (HAS_BLANK) begin
                            blank_d     = 1'b1;
                            blank_cnt_d = '0;
                            state_d     = BLANK;
                        end
                    end else begin
                        dwell_d = dwell_q + CNT_W'(1);
                    end
                end
            end
            PENDING: begin
                if (frame_start) begin
                    sel_d = pend_q;
                    if (HAS_BLANK) begin
                        blank_d     = 1'b1;
                        blank_cnt_d = '0;
                        state_d     = BLANK;
                    end else begin
                        state_d = STEADY;
                    end
                end
            end
            BLANK: begin
                if (frame_start) begin
                    if (blank_cnt_q == BLANK_LAST) begin
                        blank_d = 1'b0;
                        state_d = STEADY;
                    end else begin
                        blank_cnt_d = blank_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = STEADY;
        endcase
    end

    assign req_ready = (state_q == STEADY);
    assign busy      = (state_q != STEADY);
    assign s1        = sel_q[1];
    assign s0        = sel_q[0];
    assign blank     = blank_q;

endmodule

// File: doc/video_src_select_ctrl.md
Name: video_src_select_ctrl

Overview:
- Frame-synchronous controller that drives the s1/s0 select pair of the 16-bit 4:1 pixel source mux (x0..x3 -> out).
- Accepts manual source-change requests over a valid/ready handshake, or auto-cycles sources every DWELL_FRAMES frames.
- Applies every change only on a frame boundary and blanks the output for BLANK_FRAMES frames afterwards, so no frame ever mixes sources.
- Sits between the timing generator (frame_start) and the mux select inputs; blank drives the downstream pixel-zero gate.

Parameters:
BLANK_FRAMES, 1, frames of forced blanking after a switch (0 = no blanking)
DWELL_FRAMES, 60, frames per source in auto-cycle mode (>=1)
CNT_W, 8, width of frame counters; must hold max(BLANK_FRAMES, DWELL_FRAMES)

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
frame_start  in  1  single-cycle pulse at first active pixel of each frame
req_valid  in  1  manual source request valid
req_sel  in  2  requested source {s1,s0}: 0=x0, 1=x1, 2=x2, 3=x3
req_ready  out  1  controller can accept a request
auto_en  in  1  enable auto-cycle mode
s1  out  1  mux select MSB (registered)
s0  out  1  mux select LSB (registered)
blank  out  1  force downstream pixel to 16'h0000
busy  out  1  switch pending or blanking in progress

Behaviour:
- Reset (async, rst_n=0): s1=0, s0=0, blank=0, busy=0, req_ready=1, state=STEADY, dwell_cnt=0, blank_cnt=0, pend_sel=0.
- Reset mid-operation aborts any pending switch or blank immediately. Outputs take reset values asynchronously.
- All outputs are registered; req_ready is decoded from the state register.
- States: STEADY, PENDING, BLANK.
- STEADY:
  - req_ready=1, busy=0.
  - Handshake fires when req_valid && req_ready.
  - If req_sel != {s1,s0}: latch pend_sel, clear dwell_cnt, go to PENDING.
  - If req_sel == {s1,s0}: the request is consumed with no state change and no blanking.
  - A frame_start in the same cycle as an accepted request does not trigger the switch. The switch waits for the next frame_start.
  - Auto mode (auto_en=1, no handshake this cycle): dwell_cnt increments on each frame_start.
  - When frame_start arrives with dwell_cnt==DWELL_FRAMES-1, the controller switches directly at that frame_start to ({s1,s0}+1) mod 4 (3 wraps to 0) and clears dwell_cnt.
  - A manual handshake has priority over auto in the same cycle.
  - auto_en=0 holds dwell_cnt at 0.
- PENDING:
  - req_ready=0, busy=1; req_valid is ignored.
  - On frame_start, {s1,s0} <= pend_sel. New select is visible in the cycle after the pulse.
  - If BLANK_FRAMES>0: blank<=1, blank_cnt<=0, go to BLANK.
  - Otherwise go to STEADY.
- Switch action (manual or auto): identical timing and blanking.
- BLANK:
  - req_ready=0, busy=1, blank=1.
  - blank_cnt increments on each frame_start.
  - On frame_start with blank_cnt==BLANK_FRAMES-1: blank<=0, busy<=0, go to STEADY.
  - Net effect: blank spans exactly BLANK_FRAMES whole frames, starting with the switch frame.
- Latency: an accepted request reaches the mux selects one cycle after the first frame_start that follows acceptance.
- frame_start never causes a state change in the cycle it is missing. No timeout; PENDING holds indefinitely without frame_start.

Test Plan:
1. Async reset: drive rst_n=0 mid-BLANK (no clock edge) -> s1s0=00, blank=0, busy=0, req_ready=1 immediately. Pending switch is lost after release.
2. Manual switch, mux bench x0..x3=AAAA/BBBB/CCCC/DDDD: accept req_sel=2 at t, frame_start at t+20 and t+40 -> s1s0=10 and mux out=CCCC from t+21; blank=1 t+21..t+40; blank=0, req_ready=1 at t+41.
3. Same-source request: s1s0=01, req_sel=1 accepted -> busy stays 0, blank stays 0, req_ready stays 1.
4. Request and frame_start in the same cycle: accept req_sel=3 with frame_start high -> s1s0 unchanged. Switch occurs one cycle after the following frame_start.
5. Auto cycle, DWELL_FRAMES=3, BLANK_FRAMES=0, auto_en=1, 12 frame_starts -> s1s0 sequence 00->01->10->11->00, changing after every 3rd pulse. Manual req_sel=2 mid-dwell resets dwell_cnt.
6. Request during BLANK: req_valid=1, req_sel=0 -> req_ready=0, request ignored, s1s0 unchanged. Request is accepted on the first cycle back in STEADY if req_valid is still held.
